pool_stream_2d: RTL
===================

// Module: pool_stream_2d
// PURPOSE
//  Streaming 2D KxK pooling engine, stride = K, non-overlapping windows, over raster-order frames.
//  Keeps one row of per-column partial results, so the whole window never needs to be buffered.
//  Supports runtime frame size plus MAX/AVG/MIN modes, signed or unsigned data, and full AXI-Stream backpressure.
//  Sits between the convolution output stream and the next layer's input stream.
// PARAMETERS
//  DATA_WIDTH   8    pixel width in bits
//  KERNEL_SIZE  2    window edge K; must be 2 or 4 (power of two, so AVG is a shift)
//  MAX_WIDTH    64   largest supported cfg_width; partial buffer depth = MAX_WIDTH/K
//  MAX_HEIGHT   64   largest supported cfg_height
//  SIGNED_DATA  0    1: pixels are two's complement for compare and average
// PORTS
//  clk            in   1                        clock
//  reset          in   1                        synchronous, active-high
//  cfg_width      in   $clog2(MAX_WIDTH+1)      frame width in pixels
//  cfg_height     in   $clog2(MAX_HEIGHT+1)     frame height in rows
//  cfg_mode       in   2                        pool_mode_e: 0 MAX, 1 AVG, 2 MIN, 3 treated as MAX
//  s_axis_tvalid  in   1                        input pixel valid
//  s_axis_tready  out  1                        input pixel accepted when tvalid && tready
//  s_axis_tdata   in   DATA_WIDTH               input pixel
//  s_axis_tlast   in   1                        last pixel of frame
//  m_axis_tvalid  out  1                        pooled result valid
//  m_axis_tready  in   1                        downstream ready
//  m_axis_tdata   out  DATA_WIDTH               pooled result
//  m_axis_tlast   out  1                        last pooled result of frame
//  frame_done     out  1                        1-cycle pulse when the input tlast pixel is accepted
//  err_frame      out  1                        1-cycle pulse when tlast position != (W-1, H-1)
// BEHAVIOUR
//  Reset: all outputs 0; col/row/phase counters and the cfg shadow cleared. Reset mid-frame abandons the frame, with no output.
//  Config: cfg_* sampled into shadow registers on the first accepted pixel of each frame. Held until that frame ends.
//  Handshake: s_axis_tready = !m_axis_tvalid || m_axis_tready, combinational.
//   - m_axis_tdata/tlast are stable while tvalid && !tready.
//   - A drain and a new load in the same cycle are legal.
//  Counters:
//   - col runs 0..W-1, then wraps and increments row.
//   - kx = col mod K; ky = row mod K; oc = col / K.
//  Discard: pixels with col >= K*floor(W/K), or row >= K*floor(H/K), are accepted and ignored.
//   - Example: W=5, K=2 drops column 4.
//  Horizontal stage: kx==0 loads h_acc with the pixel; otherwise h_acc = combine(h_acc, pixel).
//  Vertical stage, on the kx==K-1 pixel, with h = combine(h_acc, pixel):
//   - ky==0: pbuf[oc] <= h.
//   - 0<ky<K-1: pbuf[oc] <= combine(pbuf[oc], h).
//   - ky==K-1: result = finalize(combine(pbuf[oc], h)), loaded into the output register.
//  Latency: m_axis_tvalid rises on the cycle after the window's last pixel is accepted.
//  combine: MAX picks the larger value, MIN picks the smaller value. Comparison is signed iff SIGNED_DATA.
//   - AVG: adds into a sum of width DATA_WIDTH+2*$clog2(K), sign-extended iff SIGNED_DATA.
//   - In AVG mode, h_acc and pbuf hold full-width sums.
//  finalize: AVG gives sum >> 2*$clog2(K), arithmetic shift iff signed, i.e. a floor. Then truncate to DATA_WIDTH.
//   - MAX and MIN pass the value through.
//  Output tlast: 1 on the result of the last window (oc = floor(W/K)-1, last full row group).
//  Frame end: an accepted s_axis_tlast pulses frame_done and resets col/row to 0. The next pixel starts a new frame.
//   - If that tlast is not at (W-1, H-1), err_frame also pulses; the partial row group is discarded.
//   - A frame with no tlast at (W-1, H-1) wraps row to 0 and continues.
//  Degenerate size (W<K or H<K): no outputs are produced; frame_done still pulses.
// STRUCTURE
//  pool_pkg: pool_mode_e enum, the SUM_W localparam function, and the combine/finalize functions, shared with the conv unit.
//  Sub-module pool_row_buffer holds the per-column partial results.
//   - Depth MAX_WIDTH/K, width SUM_W.
//   - One write port and one asynchronous read port, indexed by oc.
//  The top level holds the counters, h_acc, the cfg shadow and the output register. No explicit FSM beyond the counters.
// TESTING
//  1. K=2, MAX, 4x4 frame of pixels 1..16, tready=1 -> outputs 6, 8, 14, 16; tlast on 16; frame_done with pixel 16.
//  2. Same frame, AVG -> outputs 3, 5, 11, 13.
//  3. K=2, MAX, 5x5 frame of pixels 1..25 -> outputs 7, 9, 17, 19; tlast on 19; frame_done on pixel 25; err_frame stays 0.
//  4. SIGNED_DATA=1, AVG, one 2x2 frame {-3,-4,-5,-6} -> 0xFB (-5, floor). Same frame with MIN -> 0xFA.
//  5. Test 1 with m_axis_tready low for 5 cycles at the first result -> tdata held at 6 and s_axis_tready low throughout.
//     Then 8, 14, 16 follow with no loss or duplication.
//  6. tlast on pixel 10 of a 4x4 frame -> err_frame pulses; then a full 4x4 frame -> 6, 8, 14, 16.
//     Reset asserted mid-frame -> m_axis_tvalid=0 next cycle, and the next frame is correct.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared pooling types and arithmetic: mode encoding, sum width, combine/finalize.
package pool_pkg;

    typedef enum logic [1:0] {
        POOL_MAX  = 2'd0,
        POOL_AVG  = 2'd1,
        POOL_MIN  = 2'd2,
        POOL_RSVD = 2'd3
    } pool_mode_e;

    // Wide working type; callers sign/zero-extend operands into it first.
    localparam int unsigned CALC_W = 32;
    typedef logic [CALC_W-1:0] calc_t;

    function automatic int sum_w(input int dw, input int k);
        return dw + 2 * $clog2(k);
    endfunction

    function automatic calc_t combine(input pool_mode_e mode, input logic is_signed,
                                      input calc_t a, input calc_t b);
        logic a_gt;
        if (is_signed) a_gt = $signed(a) > $signed(b);
        else           a_gt = a > b;
        case (mode)
            POOL_AVG: return a + b;
            POOL_MIN: return a_gt ? b : a;
            default:  return a_gt ? a : b;
        endcase
    endfunction

    function automatic calc_t finalize(input pool_mode_e mode, input logic is_signed,
                                       input calc_t v, input int unsigned shift);
        calc_t r;
        r = v;
        if (mode == POOL_AVG) begin
            if (is_signed) r = $signed(v) >>> shift;
            else           r = v >> shift;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Per-output-column partial result store: one write port, one asynchronous read port.
module pool_row_buffer
    import pool_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool_stream_2d.sv
// Streaming KxK, stride-K pooling over raster frames with AXI-Stream handshakes.
module pool_stream_2d
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 2,
    parameter int MAX_WIDTH   = 64,
    parameter int MAX_HEIGHT  = 64,
    parameter int SIGNED_DATA = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
    input  logic [1:0]                      cfg_mode,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            frame_done,
    output logic                            err_frame
);

    localparam int W_W   = $clog2(MAX_WIDTH + 1);
    localparam int H_W   = $clog2(MAX_HEIGHT + 1);
    localparam int K_LOG = $clog2(KERNEL_SIZE);
    localparam int SUM_W = sum_w(DATA_WIDTH, KERNEL_SIZE);
    localparam int DEPTH = MAX_WIDTH / KERNEL_SIZE;
    localparam int OC_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SHIFT = 2 * K_LOG;
    localparam logic [K_LOG-1:0] K_LAST = K_LOG'(KERNEL_SIZE - 1);
    localparam logic IS_SIGNED = (SIGNED_DATA != 0);

    logic [W_W-1:0]        col_q, col_d, width_q, width_d;
    logic [H_W-1:0]        row_q, row_d, height_q, height_d;
    pool_mode_e            mode_q, mode_d;
    logic                  in_frame_q, in_frame_d;
    logic [SUM_W-1:0]      h_acc_q, h_acc_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  frame_done_q, frame_done_d, err_frame_q, err_frame_d;

    logic [W_W-1:0]   width_eff, wfull, owid;
    logic [H_W-1:0]   height_eff, hfull;
    pool_mode_e       mode_eff;
    logic [K_LOG-1:0] kx, ky;
    logic [OC_W-1:0]  oc;
    logic             s_accept, in_window, last_col, last_row, last_window;
    logic             pb_we;
    logic [SUM_W-1:0] pb_wdata, pb_rdata;
    calc_t            px_c, h_c, v_c;

    function automatic calc_t ext_sum(input logic [SUM_W-1:0] v);
        if (IS_SIGNED) return calc_t'($signed(v));
        return calc_t'(v);
    endfunction

    function automatic calc_t ext_px(input logic [DATA_WIDTH-1:0] v);
        if (IS_SIGNED) return calc_t'($signed(v));
        return calc_t'(v);
    endfunction

    assign s_axis_tready = !out_valid_q || m_axis_tready;
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // The first pixel of a frame must already see the live cfg, before the shadow loads.
    always_comb begin
        width_eff   = in_frame_q ? width_q  : cfg_width;
        height_eff  = in_frame_q ? height_q : cfg_height;
        mode_eff    = in_frame_q ? mode_q   : pool_mode_e'(cfg_mode);
        owid        = width_eff >> K_LOG;
        wfull       = W_W'(owid << K_LOG);
        hfull       = H_W'((height_eff >> K_LOG) << K_LOG);
        kx          = col_q[K_LOG-1:0];
        ky          = row_q[K_LOG-1:0];
        oc          = OC_W'(col_q >> K_LOG);
        in_window   = (col_q < wfull) && (row_q < hfull);
        last_col    = col_q == width_eff - 1'b1;
        last_row    = row_q == height_eff - 1'b1;
        last_window = ((col_q >> K_LOG) == owid - 1'b1) && (row_q == hfull - 1'b1);
        px_c        = ext_px(s_axis_tdata);
        h_c         = combine(mode_eff, IS_SIGNED, ext_sum(h_acc_q), px_c);
        v_c         = combine(mode_eff, IS_SIGNED, ext_sum(pb_rdata), h_c);
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        width_d      = width_q;
        height_d     = height_q;
        mode_d       = mode_q;
        in_frame_d   = in_frame_q;
        h_acc_d      = h_acc_q;
        out_valid_d  = out_valid_q && !m_axis_tready;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        err_frame_d  = 1'b0;
        pb_we        = 1'b0;
        pb_wdata     = SUM_W'(h_c);
        if (s_accept) begin
            if (!in_frame_q) begin
                width_d    = cfg_width;
                height_d   = cfg_height;
                mode_d     = pool_mode_e'(cfg_mode);
                in_frame_d = 1'b1;
            end
            if (in_window) begin
                h_acc_d = (kx == '0) ? SUM_W'(px_c) : SUM_W'(h_c);
                if (kx == K_LAST) begin
                    if (ky == '0) begin
                        pb_we = 1'b1;
                    end else if (ky != K_LAST) begin
                        pb_we    = 1'b1;
                        pb_wdata = SUM_W'(v_c);
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = DATA_WIDTH'(finalize(mode_eff, IS_SIGNED, v_c, SHIFT));
                        out_last_d  = last_window;
                    end
                end
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (s_axis_tlast) begin
                col_d        = '0;
                row_d        = '0;
                in_frame_d   = 1'b0;
                frame_done_d = 1'b1;
                err_frame_d  = !(last_col && last_row);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            mode_q       <= POOL_MAX;
            in_frame_q   <= 1'b0;
            h_acc_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            width_q      <= width_d;
            height_q     <= height_d;
            mode_q       <= mode_d;
            in_frame_q   <= in_frame_d;
            h_acc_q      <= h_acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            err_frame_q  <= err_frame_d;
        end
    end

    pool_row_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (SUM_W),
        .ADDR_W(OC_W)
    ) u_pbuf (
        .clk    (clk),
        .wr_en  (pb_we),
        .wr_addr(oc),
        .wr_data(pb_wdata),
        .rd_addr(oc),
        .rd_data(pb_rdata)
    );

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign frame_done    = frame_done_q;
    assign err_frame     = err_frame_q;

endmodule
